// File: rtl/sram_port_arbiter_if.sv
// Signal bundle between the fetch/mem requesters, the arbiter and the shared SRAM-like bus.
// The master view belongs to the arbiter, which is the single master on the memory bus.
interface sram_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [DW-1:0] inst_rdata;

  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  logic          bus_req;
  logic          bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;

  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between fetch (read-only) and mem stage (read/write), one
// transaction at a time; data has priority but fetch wins after STARVE_MAX data grants.
module sram_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_port_arbiter_if.master  port
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e        state_q;
  logic          ownerData_q;
  logic [SW-1:0] starveCnt_q;
  logic          busReq_q;
  logic          busWr_q;
  logic [1:0]    busSize_q;
  logic [AW-1:0] busAddr_q;
  logic [DW-1:0] busWdata_q;

  logic          starveHit_d;
  logic          grantData_d;
  logic [SW-1:0] starveCnt_d;

  // Fetch only overrides data once it has waited through STARVE_MAX data grants.
  always_comb begin
    starveHit_d = port.inst_req && (starveCnt_q == SW'(STARVE_MAX));
    grantData_d = port.data_req && !starveHit_d;
    starveCnt_d = '0;
    if (grantData_d && port.inst_req) begin
      starveCnt_d = starveCnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ownerData_q <= 1'b0;
      starveCnt_q <= '0;
      busReq_q    <= 1'b0;
      busWr_q     <= 1'b0;
      busSize_q   <= 2'd0;
      busAddr_q   <= '0;
      busWdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (port.data_req || port.inst_req) begin
            ownerData_q <= grantData_d;
            starveCnt_q <= starveCnt_d;
            busReq_q    <= 1'b1;
            state_q     <= ADDR;
            if (grantData_d) begin
              busWr_q    <= port.data_wr;
              busSize_q  <= port.data_size;
              busAddr_q  <= port.data_addr;
              busWdata_q <= port.data_wdata;
            end else begin
              busWr_q    <= 1'b0;
              busSize_q  <= 2'd2;
              busAddr_q  <= port.inst_addr;
              busWdata_q <= '0;
            end
          end else begin
            busReq_q <= 1'b0;
          end
        end
        ADDR: begin
          if (port.bus_addr_ok) begin
            busReq_q <= 1'b0;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (port.bus_data_ok) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshakes are also masked while reset is asserted so an aborted transaction never completes.
  assign port.inst_addr_ok = reset && (state_q == ADDR) && !ownerData_q && port.bus_addr_ok;
  assign port.data_addr_ok = reset && (state_q == ADDR) &&  ownerData_q && port.bus_addr_ok;
  assign port.inst_data_ok = reset && (state_q == DATA) && !ownerData_q && port.bus_data_ok;
  assign port.data_data_ok = reset && (state_q == DATA) &&  ownerData_q && port.bus_data_ok;
  assign port.inst_rdata   = port.bus_rdata;
  assign port.data_rdata   = port.bus_rdata;

  assign port.bus_req   = busReq_q;
  assign port.bus_wr    = busWr_q;
  assign port.bus_size  = busSize_q;
  assign port.bus_addr  = busAddr_q;
  assign port.bus_wdata = busWdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: inputs change 1ns after each rising edge and
// outputs are checked 1ns later, well before the next edge.
module tb_sram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  sram_port_arbiter_if #(.AW(AW), .DW(DW)) ifc ();

  sram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .port  (ifc.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction with an always-ready bus and reports which port got the grant.
  task automatic busTxn(output logic gotData, output logic gotInst, output logic [AW-1:0] gotAddr);
    tick();
    ifc.bus_addr_ok = 1'b1;
    #1;
    gotData = ifc.data_addr_ok;
    gotInst = ifc.inst_addr_ok;
    gotAddr = ifc.bus_addr;
    tick();
    ifc.bus_addr_ok = 1'b0;
    ifc.bus_data_ok = 1'b1;
    tick();
    ifc.bus_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC0_0000;
    ifc.data_req = 1'b1; ifc.data_wr = 1'b1; ifc.data_size = 2'd2;
    ifc.data_addr = 32'h1000_0000; ifc.data_wdata = 32'h1111_2222;
    ifc.bus_addr_ok = 1'b1; ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ifc.bus_req !== 1'b0 || ifc.bus_addr !== 32'h0 || ifc.bus_wdata !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_bus cyc %0d: req=%b addr=%h wdata=%h, required 0/0/0", i, ifc.bus_req, ifc.bus_addr, ifc.bus_wdata);
      end
      checks++;
      if ({ifc.inst_addr_ok, ifc.inst_data_ok, ifc.data_addr_ok, ifc.data_data_ok} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_oks cyc %0d: got %b, required 0000", i,
                 {ifc.inst_addr_ok, ifc.inst_data_ok, ifc.data_addr_ok, ifc.data_data_ok});
      end
    end
    ifc.inst_req = 1'b0; ifc.data_req = 1'b0;
    ifc.bus_addr_ok = 1'b0; ifc.bus_data_ok = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (ifc.bus_req !== 1'b0 || ifc.bus_wr !== 1'b0 || ifc.bus_size !== 2'd0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: req=%b wr=%b size=%0d, required 0/0/0", ifc.bus_req, ifc.bus_wr, ifc.bus_size);
    end
  endtask

  task automatic test_inst_read();
    ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC0_0000;
    tick();
    checks++;
    if (ifc.bus_req !== 1'b1 || ifc.bus_addr !== 32'hBFC0_0000 || ifc.bus_wr !== 1'b0 || ifc.bus_size !== 2'd2) begin
      errors++;
      $display("[TB] FAIL inst_latch: req=%b addr=%h wr=%b size=%0d, required 1/bfc00000/0/2", ifc.bus_req, ifc.bus_addr, ifc.bus_wr, ifc.bus_size);
    end
    checks++;
    if (ifc.inst_addr_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inst_addr_ok_early: got %b, required 0", ifc.inst_addr_ok);
    end
    ifc.bus_addr_ok = 1'b1;
    #1;
    checks++;
    if (ifc.inst_addr_ok !== 1'b1 || ifc.data_addr_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inst_addr_ok: inst=%b data=%b, required 1/0", ifc.inst_addr_ok, ifc.data_addr_ok);
    end
    tick();
    ifc.bus_addr_ok = 1'b0; ifc.inst_req = 1'b0;
    #1;
    checks++;
    if (ifc.bus_req !== 1'b0 || ifc.inst_data_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inst_data_wait: req=%b data_ok=%b, required 0/0", ifc.bus_req, ifc.inst_data_ok);
    end
    tick();
    ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h2408_0001;
    #1;
    checks++;
    if (ifc.inst_data_ok !== 1'b1 || ifc.inst_rdata !== 32'h2408_0001 || ifc.data_data_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inst_data_ok: ok=%b rdata=%h data_ok=%b, required 1/24080001/0", ifc.inst_data_ok, ifc.inst_rdata, ifc.data_data_ok);
    end
    tick();
    checks++;
    if (ifc.inst_data_ok !== 1'b0 || ifc.bus_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inst_back_idle_stray: data_ok=%b req=%b, required 0/0", ifc.inst_data_ok, ifc.bus_req);
    end
    ifc.bus_data_ok = 1'b0;
  endtask

  task automatic test_data_priority();
    ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC0_0004;
    ifc.data_req = 1'b1; ifc.data_wr = 1'b1; ifc.data_size = 2'd2;
    ifc.data_addr = 32'h1000_0004; ifc.data_wdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (ifc.bus_wr !== 1'b1 || ifc.bus_addr !== 32'h1000_0004 || ifc.bus_wdata !== 32'hDEAD_BEEF || ifc.bus_size !== 2'd2) begin
      errors++;
      $display("[TB] FAIL data_latch: wr=%b addr=%h wdata=%h size=%0d, required 1/10000004/deadbeef/2", ifc.bus_wr, ifc.bus_addr, ifc.bus_wdata, ifc.bus_size);
    end
    ifc.bus_addr_ok = 1'b1;
    #1;
    checks++;
    if (ifc.data_addr_ok !== 1'b1 || ifc.inst_addr_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL data_addr_ok: data=%b inst=%b, required 1/0", ifc.data_addr_ok, ifc.inst_addr_ok);
    end
    tick();
    ifc.bus_addr_ok = 1'b0; ifc.data_req = 1'b0; ifc.bus_data_ok = 1'b1;
    #1;
    checks++;
    if (ifc.data_data_ok !== 1'b1 || ifc.inst_data_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL data_data_ok: data=%b inst=%b, required 1/0", ifc.data_data_ok, ifc.inst_data_ok);
    end
    tick();
    ifc.bus_data_ok = 1'b0;
    tick();
    checks++;
    if (ifc.bus_req !== 1'b1 || ifc.bus_wr !== 1'b0 || ifc.bus_addr !== 32'hBFC0_0004 || ifc.bus_wdata !== 32'h0 || ifc.bus_size !== 2'd2) begin
      errors++;
      $display("[TB] FAIL inst_after_data: req=%b wr=%b addr=%h wdata=%h size=%0d, required 1/0/bfc00004/0/2", ifc.bus_req, ifc.bus_wr, ifc.bus_addr, ifc.bus_wdata, ifc.bus_size);
    end
    ifc.bus_addr_ok = 1'b1;
    #1;
    checks++;
    if (ifc.inst_addr_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL inst_after_data_addr_ok: got %b, required 1", ifc.inst_addr_ok);
    end
    tick();
    ifc.bus_addr_ok = 1'b0; ifc.inst_req = 1'b0; ifc.bus_data_ok = 1'b1;
    tick();
    ifc.bus_data_ok = 1'b0;
  endtask

  task automatic test_starvation();
    logic          gotData;
    logic          gotInst;
    logic [AW-1:0] gotAddr;
    logic [9:0]    expData;
    expData = 10'b1111011110;
    ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC0_0200;
    ifc.data_req = 1'b1; ifc.data_wr = 1'b0; ifc.data_size = 2'd2;
    ifc.data_addr = 32'h1000_0100; ifc.data_wdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      busTxn(gotData, gotInst, gotAddr);
      checks++;
      if (gotData !== expData[9 - i] || gotInst !== !expData[9 - i] ||
          gotAddr !== (expData[9 - i] ? 32'h1000_0100 : 32'hBFC0_0200)) begin
        errors++;
        $display("[TB] FAIL starve_order grant %0d: data=%b inst=%b addr=%h, required data=%b", i, gotData, gotInst, gotAddr, expData[9 - i]);
      end
    end
    ifc.inst_req = 1'b0; ifc.data_req = 1'b0;
  endtask

  task automatic test_addr_stall();
    ifc.data_req = 1'b1; ifc.data_wr = 1'b1; ifc.data_size = 2'd1;
    ifc.data_addr = 32'h2000_0008; ifc.data_wdata = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) begin
        ifc.data_req = 1'b0; ifc.data_addr = 32'hFFFF_FFFF; ifc.data_wdata = 32'h0;
      end
      #1;
      checks++;
      if (ifc.bus_req !== 1'b1 || ifc.bus_addr !== 32'h2000_0008 || ifc.bus_wdata !== 32'h1234_5678 ||
          ifc.bus_wr !== 1'b1 || ifc.bus_size !== 2'd1) begin
        errors++;
        $display("[TB] FAIL stall_hold cyc %0d: req=%b addr=%h wdata=%h wr=%b size=%0d, required 1/20000008/12345678/1/1", i, ifc.bus_req, ifc.bus_addr, ifc.bus_wdata, ifc.bus_wr, ifc.bus_size);
      end
      checks++;
      if (ifc.data_addr_ok !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_no_addr_ok cyc %0d: got %b, required 0", i, ifc.data_addr_ok);
      end
    end
    ifc.bus_addr_ok = 1'b1;
    #1;
    checks++;
    if (ifc.data_addr_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_addr_ok: got %b, required 1", ifc.data_addr_ok);
    end
    tick();
    ifc.bus_addr_ok = 1'b0;
    #1;
    checks++;
    if (ifc.data_data_ok !== 1'b0 || ifc.bus_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_data_wait: data_ok=%b req=%b, required 0/0", ifc.data_data_ok, ifc.bus_req);
    end
    tick();
    ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (ifc.data_data_ok !== 1'b1 || ifc.data_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("[TB] FAIL stall_complete: ok=%b rdata=%h, required 1/cafef00d", ifc.data_data_ok, ifc.data_rdata);
    end
    tick();
    ifc.bus_data_ok = 1'b0;
    tick();
    checks++;
    if (ifc.bus_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_no_retrigger: req=%b, required 0", ifc.bus_req);
    end
  endtask

  task automatic test_reset_abort();
    ifc.inst_req = 1'b1; ifc.inst_addr = 32'hBFC0_0100;
    tick();
    ifc.bus_addr_ok = 1'b1;
    #1;
    checks++;
    if (ifc.inst_addr_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_addr_ok: got %b, required 1", ifc.inst_addr_ok);
    end
    tick();
    ifc.bus_addr_ok = 1'b0; ifc.inst_req = 1'b0; reset = 1'b0;
    #1;
    checks++;
    if (ifc.inst_data_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_in_reset: data_ok=%b, required 0", ifc.inst_data_ok);
    end
    tick();
    reset = 1'b1; ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h0BAD_0BAD;
    #1;
    checks++;
    if (ifc.inst_data_ok !== 1'b0 || ifc.data_data_ok !== 1'b0 || ifc.bus_req !== 1'b0 || ifc.bus_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL abort_late_data: inst_ok=%b data_ok=%b req=%b addr=%h, required 0/0/0/0", ifc.inst_data_ok, ifc.data_data_ok, ifc.bus_req, ifc.bus_addr);
    end
    tick();
    ifc.bus_data_ok = 1'b0;
    ifc.data_req = 1'b1; ifc.data_wr = 1'b0; ifc.data_size = 2'd2;
    ifc.data_addr = 32'h0000_0030; ifc.data_wdata = 32'h0;
    tick();
    checks++;
    if (ifc.bus_req !== 1'b1 || ifc.bus_addr !== 32'h0000_0030 || ifc.bus_wr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_next_latch: req=%b addr=%h wr=%b, required 1/00000030/0", ifc.bus_req, ifc.bus_addr, ifc.bus_wr);
    end
    ifc.bus_addr_ok = 1'b1;
    #1;
    checks++;
    if (ifc.data_addr_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_next_addr_ok: got %b, required 1", ifc.data_addr_ok);
    end
    tick();
    ifc.data_req = 1'b0; ifc.bus_addr_ok = 1'b0; ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h5555_AAAA;
    #1;
    checks++;
    if (ifc.data_data_ok !== 1'b1 || ifc.data_rdata !== 32'h5555_AAAA) begin
      errors++;
      $display("[TB] FAIL abort_next_data: ok=%b rdata=%h, required 1/5555aaaa", ifc.data_data_ok, ifc.data_rdata);
    end
    tick();
    ifc.bus_data_ok = 1'b0;
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_data_priority();
    test_starvation();
    test_addr_stall();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
